// File: rtl/cmp_arb_pkg.sv
// Shared types and widths for the round-robin comparator arbiter.
// Holds the FSM state encoding and the datapath/counter widths.
// Imported by cmp_arbiter and mag_cmp4.
package cmp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RSP  = 2'd2
    } state_t;

    localparam int CW = 4;   // comparator operand width
    localparam int SW = 16;  // statistics counter width

endpackage

// File: rtl/mag_cmp4.sv
// Unsigned 4-bit magnitude comparator producing one-hot gt/lt/eq.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module mag_cmp4
    import cmp_arb_pkg::*;
(
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    output logic          gt,
    output logic          lt,
    output logic          eq
);

    // exactly one flag is high for any operand pair
    always_comb begin
        gt = (a > b);
        lt = (a < b);
        eq = (a == b);
    end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin scheduler sharing one 4-bit comparator among NREQ requesters.
// Latency: grant in cycle N, registered result valid from cycle N+2; 3-cycle grant spacing.
// Backpressure: rsp_ready low holds the result in RSP; no grants until the handshake.
// Optional statistics counters (done_cnt, eq_cnt) are enabled by defining CMP_ARB_STATS_EN.
module cmp_arbiter
    import cmp_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 3
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [CW*NREQ-1:0] req_a,
    input  logic [CW*NREQ-1:0] req_b,
    output logic [NREQ-1:0]    req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic               rsp_gt,
    output logic               rsp_lt,
    output logic               rsp_eq
`ifdef CMP_ARB_STATS_EN
    ,
    output logic [SW-1:0]      done_cnt,
    output logic [SW-1:0]      eq_cnt
`endif
);

    // First valid lane at or after ptr, wrapping; MSB of the result flags "found".
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] vld,
                                             input logic [IDW-1:0]  ptr);
        logic [IDW-1:0] hi;
        logic [IDW-1:0] lo;
        logic           hi_found;
        logic           lo_found;
        hi       = '0;
        lo       = '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        // descending scan so the lowest qualifying index is written last
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (vld[i]) begin
                lo       = IDW'(i);
                lo_found = 1'b1;
                if (IDW'(i) >= ptr) begin
                    hi       = IDW'(i);
                    hi_found = 1'b1;
                end
            end
        end
        return hi_found ? {1'b1, hi} : {lo_found, lo};
    endfunction

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]   a_q, a_d;
    logic [CW-1:0]   b_q, b_d;
    logic [IDW-1:0]  id_q, id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic            rsp_gt_q, rsp_gt_d;
    logic            rsp_lt_q, rsp_lt_d;
    logic            rsp_eq_q, rsp_eq_d;

    logic [IDW:0]    pick;
    logic [IDW-1:0]  win;
    logic            grant;
    logic [CW-1:0]   a_sel;
    logic [CW-1:0]   b_sel;
    logic            cmp_gt, cmp_lt, cmp_eq;

    mag_cmp4 u_cmp (
        .a  (a_q),
        .b  (b_q),
        .gt (cmp_gt),
        .lt (cmp_lt),
        .eq (cmp_eq)
    );

    // Grant decision and operand mux; req_ready is only ever high in IDLE
    always_comb begin
        pick      = rr_pick(req_valid, ptr_q);
        win       = pick[IDW-1:0];
        grant     = pick[IDW] && (state_q == IDLE) && !rst;
        req_ready = grant ? (NREQ'(1) << win) : '0;
        a_sel     = '0;
        b_sel     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                a_sel = req_a[i*CW +: CW];
                b_sel = req_b[i*CW +: CW];
            end
        end
    end

    // FSM next-state and registered response computation
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_gt_d    = rsp_gt_q;
        rsp_lt_d    = rsp_lt_q;
        rsp_eq_d    = rsp_eq_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    a_d     = a_sel;
                    b_d     = b_sel;
                    id_d    = win;
                    ptr_d   = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
                    state_d = CMP;
                end
            end
            CMP: begin
                rsp_gt_d    = cmp_gt;
                rsp_lt_d    = cmp_lt;
                rsp_eq_d    = cmp_eq;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_gt_q    <= 1'b0;
            rsp_lt_q    <= 1'b0;
            rsp_eq_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_gt_q    <= rsp_gt_d;
            rsp_lt_q    <= rsp_lt_d;
            rsp_eq_q    <= rsp_eq_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_gt    = rsp_gt_q;
    assign rsp_lt    = rsp_lt_q;
    assign rsp_eq    = rsp_eq_q;

`ifdef CMP_ARB_STATS_EN
    logic [SW-1:0] done_cnt_q, done_cnt_d;
    logic [SW-1:0] eq_cnt_q, eq_cnt_d;
    logic          hs;

    // Saturating handshake counters
    always_comb begin
        hs         = rsp_valid_q && rsp_ready;
        done_cnt_d = done_cnt_q;
        eq_cnt_d   = eq_cnt_q;
        if (hs && (done_cnt_q != '1)) begin
            done_cnt_d = done_cnt_q + 1'b1;
        end
        if (hs && rsp_eq_q && (eq_cnt_q != '1)) begin
            eq_cnt_d = eq_cnt_q + 1'b1;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            done_cnt_q <= '0;
            eq_cnt_q   <= '0;
        end else begin
            done_cnt_q <= done_cnt_d;
            eq_cnt_q   <= eq_cnt_d;
        end
    end

    assign done_cnt = done_cnt_q;
    assign eq_cnt   = eq_cnt_q;
`endif

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed self-checking bench for cmp_arbiter (NREQ=4, IDW=3).
// Inputs are driven 2 time units after the rising edge; outputs checked 1 unit later.
// Statistics checks compile only when CMP_ARB_STATS_EN is defined.
module tb_cmp_arbiter;
    import cmp_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 3;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [CW*NREQ-1:0] req_a;
    logic [CW*NREQ-1:0] req_b;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic               rsp_gt;
    logic               rsp_lt;
    logic               rsp_eq;
`ifdef CMP_ARB_STATS_EN
    logic [SW-1:0]      done_cnt;
    logic [SW-1:0]      eq_cnt;
`endif

    int total = 0;
    int bad   = 0;

    cmp_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_gt    (rsp_gt),
        .rsp_lt    (rsp_lt),
        .rsp_eq    (rsp_eq)
`ifdef CMP_ARB_STATS_EN
        ,
        .done_cnt  (done_cnt),
        .eq_cnt    (eq_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock; land 2 units after the rising edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // one full transaction from an IDLE cycle with rsp_ready high; returns in IDLE
    task automatic xact(input int lane, input logic [3:0] a, input logic [3:0] b);
        req_valid          = '0;
        req_valid[lane]    = 1'b1;
        req_a[lane*4 +: 4] = a;
        req_b[lane*4 +: 4] = b;
        rsp_ready          = 1'b1;
        step();
        req_valid = '0;
        step();
        step();
    endtask

    int          gl_lane [5] = '{0, 1, 2, 3, 0};
    logic [2:0]  gl_res  [5] = '{3'b010, 3'b001, 3'b100, 3'b100, 3'b010};
    logic [3:0]  ed_a    [4] = '{4'd15, 4'd0, 4'd15, 4'd0};
    logic [3:0]  ed_b    [4] = '{4'd0, 4'd15, 4'd15, 4'd0};
    logic [2:0]  ed_res  [4] = '{3'b100, 3'b010, 3'b001, 3'b001};

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_id",    32'(rsp_id), 32'h0);
        chk("rst_flags",     32'({rsp_gt, rsp_lt, rsp_eq}), 32'h0);
        chk("rst_ptr",       32'(dut.ptr_q), 32'h0);
        step();
        rst = 1'b0;

        // ---------------- single request, lane 2 ----------------
        req_valid = 4'b0100;
        req_a     = 16'h0900;
        req_b     = 16'h0300;
        rsp_ready = 1'b1;
        #1;
        chk("single_grant", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        #1;
        chk("single_cmp_ready", 32'(req_ready), 32'h0);
        chk("single_cmp_valid", 32'(rsp_valid), 32'h0);
        chk("single_ptr", 32'(dut.ptr_q), 32'h3);
        step();
        #1;
        chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("single_rsp_id", 32'(rsp_id), 32'h2);
        chk("single_rsp_flags", 32'({rsp_gt, rsp_lt, rsp_eq}), 32'h4);
        step();
        #1;
        chk("single_back_idle", 32'(rsp_valid), 32'h0);
        chk("single_idle_state", 32'(dut.state_q), 32'(IDLE));

        // ---------------- all four lanes from reset ----------------
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 4'b1111;
        req_a     = 16'h3210;
        req_b     = 16'h1111;
        rsp_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            #1;
            chk("rr_grant", 32'(req_ready), 32'(1 << gl_lane[g]));
            step();
            #1;
            chk("rr_cmp_noready", 32'(req_ready), 32'h0);
            step();
            #1;
            chk("rr_rsp_id", 32'(rsp_id), 32'(gl_lane[g]));
            chk("rr_rsp_flags", 32'({rsp_gt, rsp_lt, rsp_eq}), 32'(gl_res[g]));
            chk("rr_rsp_noready", 32'(req_ready), 32'h0);
            step();
        end

        // ---------------- backpressure ----------------
        // ptr is 1 here; only lane 0 valid so the pick must wrap
        req_valid = 4'b0001;
        req_a     = 16'h0005;
        req_b     = 16'h0005;
        rsp_ready = 1'b0;
        #1;
        chk("bp_grant_wrap", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b1111;
        req_a     = 16'hFFFF;
        req_b     = 16'h0000;
        step();
        #1;
        chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("bp_rsp_eq", 32'({rsp_gt, rsp_lt, rsp_eq}), 32'h1);
        for (int s = 0; s < 5; s++) begin
            step();
            #1;
            chk("bp_hold_valid", 32'(rsp_valid), 32'h1);
            chk("bp_hold_id", 32'(rsp_id), 32'h0);
            chk("bp_hold_flags", 32'({rsp_gt, rsp_lt, rsp_eq}), 32'h1);
            chk("bp_no_grant", 32'(req_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        step();
        #1;
        chk("bp_after_hs_valid", 32'(rsp_valid), 32'h0);
        chk("bp_next_grant", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        step();
        #1;
        chk("bp_lane1_id", 32'(rsp_id), 32'h1);
        chk("bp_lane1_gt", 32'({rsp_gt, rsp_lt, rsp_eq}), 32'h4);
        step();

        // ---------------- edge operands on lane 1 ----------------
        for (int e = 0; e < 4; e++) begin
            req_valid = 4'b0010;
            req_a     = {8'h00, ed_a[e], 4'h0};
            req_b     = {8'h00, ed_b[e], 4'h0};
            #1;
            chk("edge_grant", 32'(req_ready), 32'h2);
            step();
            req_valid = '0;
            step();
            #1;
            chk("edge_flags", 32'({rsp_gt, rsp_lt, rsp_eq}), 32'(ed_res[e]));
            step();
        end

        // ---------------- reset during RSP ----------------
        req_valid = 4'b1000;
        req_a     = 16'h1000;
        req_b     = 16'h2000;
        rsp_ready = 1'b0;
        #1;
        chk("rstrsp_grant3", 32'(req_ready), 32'h8);
        step();
        step();
        #1;
        chk("rstrsp_valid_before", 32'(rsp_valid), 32'h1);
        rst = 1'b1;
        step();
        #1;
        chk("rstrsp_valid_after", 32'(rsp_valid), 32'h0);
        chk("rstrsp_ptr", 32'(dut.ptr_q), 32'h0);
        chk("rstrsp_ready_in_rst", 32'(req_ready), 32'h0);
        rst = 1'b0;
        #1;
        chk("rstrsp_lane3_alone", 32'(req_ready), 32'h8);
        req_valid = 4'b1010;
        #1;
        chk("rstrsp_lower_first", 32'(req_ready), 32'h2);
        rsp_ready = 1'b1;
        step();
        req_valid = '0;
        step();
        step();

`ifdef CMP_ARB_STATS_EN
        // ---------------- statistics counters ----------------
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("stats_rst_done", 32'(done_cnt), 32'h0);
        chk("stats_rst_eq", 32'(eq_cnt), 32'h0);
        xact(0, 4'd3, 4'd7);
        xact(1, 4'd6, 4'd6);
        xact(2, 4'd9, 4'd1);
        #1;
        chk("stats_done3", 32'(done_cnt), 32'h3);
        chk("stats_eq1", 32'(eq_cnt), 32'h1);
        force dut.done_cnt_q = 16'hFFFF;
        #1;
        release dut.done_cnt_q;
        xact(3, 4'd2, 4'd8);
        #1;
        chk("stats_sat", 32'(done_cnt), 32'hFFFF);
        chk("stats_eq_hold", 32'(eq_cnt), 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
